// File: rtl/baud_gen_pkg.sv
// rtl/baud_gen_pkg.sv - shared defaults and limits for the fractional baud generator
package baud_gen_pkg;

    localparam int OVERSAMPLE_DEF = 16;
    localparam int DIV_W_DEF      = 16;
    localparam int FRAC_W_DEF     = 8;
    // Divisors below this are clamped so a tick can never fire every cycle.
    localparam int MIN_DIV        = 2;

endpackage

// File: rtl/baud_frac_acc.sv
// rtl/baud_frac_acc.sv - fractional phase accumulator; carry-out stretches the next tick period
module baud_frac_acc
    import baud_gen_pkg::*;
#(
    parameter int FRAC_W = FRAC_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              step_i,
    input  logic [FRAC_W-1:0] frac_i,
    output logic              stretch_o
);

    logic [FRAC_W-1:0] acc_q, acc_d;
    logic              stretch_q, stretch_d;

    always_comb begin
        acc_d     = acc_q;
        stretch_d = stretch_q;
        if (clear_i) begin
            acc_d     = '0;
            stretch_d = 1'b0;
        end else if (step_i) begin
            {stretch_d, acc_d} = {1'b0, acc_q} + {1'b0, frac_i};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q     <= '0;
            stretch_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            stretch_q <= stretch_d;
        end
    end

    assign stretch_o = stretch_q;

endmodule

// File: rtl/baud_gen_frac.sv
// rtl/baud_gen_frac.sv - oversample/mid/baud tick generator; BAUD_GEN_FRAC_EN adds the fractional divisor
module baud_gen_frac
    import baud_gen_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int DIV_W      = DIV_W_DEF,
    parameter int FRAC_W     = FRAC_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              restart,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    output logic              os_tick,
    output logic              mid_tick,
    output logic              baud_tick
);

    localparam int OS_W = $clog2(OVERSAMPLE);

    logic             en_q;
    logic [DIV_W-1:0] eff_int_q;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [OS_W-1:0]  os_cnt_q, os_cnt_d;
    logic             os_tick_q, os_tick_d;
    logic             mid_q, mid_d;
    logic             baud_q, baud_d;
    logic             load;
    logic             terminal;
    logic             stretch;
    logic [DIV_W:0]   p_int;
    logic [DIV_W:0]   last;

    // Shadows reload on restart and on the first enabled cycle; that cycle never counts.
    assign load     = restart | (enable & ~en_q);
    assign p_int    = (eff_int_q < DIV_W'(MIN_DIV)) ? (DIV_W+1)'(MIN_DIV) : {1'b0, eff_int_q};
    assign last     = p_int + (DIV_W+1)'(stretch) - (DIV_W+1)'(1);
    assign terminal = enable & ~load & ({1'b0, cnt_q} == last);

`ifdef BAUD_GEN_FRAC_EN
    logic [FRAC_W-1:0] eff_frac_q;

    always_ff @(posedge clk) begin
        if (rst || load || terminal) begin
            eff_frac_q <= div_frac;
        end
    end

    baud_frac_acc #(
        .FRAC_W (FRAC_W)
    ) u_frac_acc (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (load | ~enable),
        .step_i    (terminal),
        .frac_i    (eff_frac_q),
        .stretch_o (stretch)
    );
`else
    logic unused_frac;
    assign unused_frac = ^div_frac;
    assign stretch     = 1'b0;
`endif

    always_comb begin
        cnt_d     = cnt_q;
        os_cnt_d  = os_cnt_q;
        os_tick_d = 1'b0;
        mid_d     = 1'b0;
        baud_d    = 1'b0;
        if (load || !enable) begin
            cnt_d    = '0;
            os_cnt_d = '0;
        end else if (terminal) begin
            cnt_d     = '0;
            os_cnt_d  = os_cnt_q + OS_W'(1);
            os_tick_d = 1'b1;
            mid_d     = (os_cnt_q == OS_W'(OVERSAMPLE/2 - 1));
            baud_d    = (os_cnt_q == OS_W'(OVERSAMPLE - 1));
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en_q      <= 1'b0;
            eff_int_q <= div_int;
            cnt_q     <= '0;
            os_cnt_q  <= '0;
            os_tick_q <= 1'b0;
            mid_q     <= 1'b0;
            baud_q    <= 1'b0;
        end else begin
            en_q      <= enable;
            if (load || terminal) begin
                eff_int_q <= div_int;
            end
            cnt_q     <= cnt_d;
            os_cnt_q  <= os_cnt_d;
            os_tick_q <= os_tick_d;
            mid_q     <= mid_d;
            baud_q    <= baud_d;
        end
    end

    assign os_tick   = os_tick_q;
    assign mid_tick  = mid_q;
    assign baud_tick = baud_q;

endmodule

// File: tb/tb_baud_gen_frac.sv
// tb/tb_baud_gen_frac.sv - directed self-checking bench for baud_gen_frac
module tb_baud_gen_frac;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        restart;
    logic [15:0] div_int;
    logic [7:0]  div_frac;
    logic        os_tick;
    logic        mid_tick;
    logic        baud_tick;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;
    int last_t;
    int idx;

`ifdef BAUD_GEN_FRAC_EN
    localparam int FRAC_TOTAL = 6944;
    localparam int FRAC_N28   = 32;
`else
    localparam int FRAC_TOTAL = 6912;
    localparam int FRAC_N28   = 0;
`endif

    baud_gen_frac dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .restart   (restart),
        .div_int   (div_int),
        .div_frac  (div_frac),
        .os_tick   (os_tick),
        .mid_tick  (mid_tick),
        .baud_tick (baud_tick)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic wait_os(input int budget, output int at, output int m, output int b);
        at = -1000000;
        m  = 0;
        b  = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (os_tick) begin
                at = cyc;
                m  = int'(mid_tick);
                b  = int'(baud_tick);
                break;
            end
        end
    endtask

    task automatic tick_check(input string tag, input int period);
        int at, m, b;
        wait_os(100, at, m, b);
        idx++;
        check({tag, "_period"}, at - last_t, period);
        check({tag, "_mid"}, m, int'(idx % 16 == 8));
        check({tag, "_baud"}, b, int'(idx % 16 == 0));
        last_t = at;
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        check("restart_cycle_os", int'(os_tick), 0);
        last_t = cyc;
        idx    = 0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_os"}, int'(os_tick), 0);
        check({tag, "_mid"}, int'(mid_tick), 0);
        check({tag, "_baud"}, int'(baud_tick), 0);
    endtask

    initial begin
        int b16, at, m, b, n, n28, t1;
        rst      = 1'b1;
        enable   = 1'b1;
        restart  = 1'b1;
        div_int  = 16'd27;
        div_frac = 8'd0;
        repeat (3) begin
            @(negedge clk);
            check_quiet("in_reset");
        end

        rst     = 1'b0;
        restart = 1'b0;
        last_t  = cyc + 1;
        idx     = 0;
        @(negedge clk);
        check_quiet("after_reset");

        b16 = 0;
        for (int i = 1; i <= 32; i++) begin
            tick_check("p27", 27);
            if (i == 16) b16 = last_t;
            if (i == 24) check("mid_after_baud", last_t - b16, 216);
        end
        check("baud_period", last_t - b16, 432);

        repeat (10) @(negedge clk);
        div_int = 16'd40;
        tick_check("chg_cur", 27);
        tick_check("chg_new", 40);
        tick_check("chg_new2", 40);

        div_int = 16'd27;
        repeat (9) @(negedge clk);
        pulse_restart();
        for (int i = 1; i <= 16; i++) tick_check("after_restart", 27);

        repeat (26) @(negedge clk);
        pulse_restart();
        tick_check("restart_on_term", 27);

        div_int = 16'd0;
        pulse_restart();
        repeat (3) tick_check("div0", 2);
        div_int = 16'd1;
        pulse_restart();
        repeat (3) tick_check("div1", 2);

        enable = 1'b0;
        n = 0;
        repeat (10) begin
            @(negedge clk);
            if (os_tick || mid_tick || baud_tick) n++;
        end
        check("idle_ticks", n, 0);
        enable = 1'b1;
        last_t = cyc + 1;
        idx    = 0;
        tick_check("reenable", 2);

        div_int  = 16'd27;
        div_frac = 8'h20;
        pulse_restart();
        tick_check("frac_first", 27);
        t1  = last_t;
        n28 = 0;
        for (int i = 0; i < 256; i++) begin
            wait_os(100, at, m, b);
            if (at - last_t == 28) n28++;
            last_t = at;
        end
        check("frac_total", last_t - t1, FRAC_TOTAL);
        check("frac_n28", n28, FRAC_N28);

        div_frac = 8'd0;
        pulse_restart();
        repeat (5) tick_check("pre_rst", 27);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_quiet("mid_bit_rst");
        rst    = 1'b0;
        last_t = cyc + 1;
        idx    = 0;
        @(negedge clk);
        check_quiet("after_mid_rst");
        for (int i = 1; i <= 8; i++) tick_check("post_rst", 27);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/baud_gen_frac.md
BAUD_GEN_FRAC -- requirements
Module: baud_gen_frac

Interface
REQ-001 Parameter OVERSAMPLE, default 16, oversample ticks per bit; power of two, 4..64.
REQ-002 Parameter DIV_W, default 16, width of the integer divisor.
REQ-003 Parameter FRAC_W, default 8, width of the fractional divisor.
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 enable  input  1  run the generator; low holds it idle.
REQ-007 restart  input  1  single-cycle pulse that realigns the tick phase.
REQ-008 div_int  input  DIV_W  integer clocks per oversample tick.
REQ-009 div_frac  input  FRAC_W  fractional clocks per oversample tick, in units of 2^-FRAC_W.
REQ-010 os_tick  output  1  one-cycle pulse per oversample period.
REQ-011 mid_tick  output  1  one-cycle pulse at mid-bit; this is the RX sample point.
REQ-012 baud_tick  output  1  one-cycle pulse per bit period.

Function
REQ-013 Mean os_tick period SHALL be div_int + div_frac/2^FRAC_W clocks.
- Period counter runs 0..P-1, with P = eff_int, or eff_int+1 when the current period is stretched.
REQ-014 Fractional accumulator (FRAC_W bits) SHALL add eff_frac at every os_tick.
- Carry-out stretches the next period by exactly one clock.
- Wraps modulo 2^FRAC_W.
REQ-015 eff_int/eff_frac SHALL be shadow copies of div_int/div_frac.
- Loaded at every os_tick, at restart, and on the first enabled cycle after idle.
- Input changes never alter a period in progress.
REQ-016 eff_int values 0 and 1 SHALL be treated as 2.
REQ-017 Sub-counter os_cnt (log2 OVERSAMPLE bits) SHALL increment on each os_tick and wrap at OVERSAMPLE-1.
REQ-018 baud_tick SHALL assert in the same cycle as the os_tick for which os_cnt == OVERSAMPLE-1.
REQ-019 mid_tick SHALL assert in the same cycle as the os_tick for which os_cnt == OVERSAMPLE/2-1.
REQ-020 All outputs SHALL be registered and each pulse SHALL last exactly one clk cycle.
REQ-021 If enable rises at cycle 0 with eff_int=N and no stretch, the first os_tick SHALL occur at cycle N.
REQ-022 enable low SHALL do all of the following:
- zero the period counter, os_cnt and the accumulator;
- hold them at zero;
- suppress all ticks.
REQ-023 restart SHALL act regardless of enable and has priority over normal counting.
- Clears the period counter, os_cnt and the accumulator, and reloads the shadows.
- No tick is emitted in the restart cycle.
- With enable high, the next os_tick follows eff_int clocks later.
REQ-024 restart coinciding with a terminal count SHALL suppress that tick.

Reset
REQ-025 rst SHALL clear the period counter, os_cnt and the accumulator, and set the shadows to current inputs.
REQ-026 During reset and in the cycle after reset, os_tick, mid_tick and baud_tick SHALL be 0.
REQ-027 Reset SHALL override restart and enable.

Configuration
REQ-028 Macro BAUD_GEN_FRAC_EN defined: fractional accumulation and period stretching per REQ-013/014.
REQ-029 Macro BAUD_GEN_FRAC_EN undefined:
- div_frac is ignored and no accumulator is built;
- the period is exactly eff_int;
- all other behaviour is identical.

Structure
REQ-030 Package baud_gen_pkg SHALL hold the default OVERSAMPLE/DIV_W/FRAC_W constants and the minimum-divisor constant (2).
REQ-031 The accumulator and stretch decision SHALL live in sub-module baud_frac_acc, instantiated only under BAUD_GEN_FRAC_EN.

Verification
REQ-032 OVERSAMPLE=16, div_int=27, div_frac=0, enable held -> os_tick every 27 clks; baud_tick every 432 clks; mid_tick 216 clks after each baud_tick.
REQ-033 div_int=27, div_frac=0x20 (FRAC_W=8), macro on -> over 256 os_ticks exactly 32 periods of 28 clks and 224 of 27, 6944 clks total; macro off -> 6912 clks.
REQ-034 restart pulsed 10 clks into a 27-clk period -> no tick that cycle; next os_tick 27 clks later; os_cnt restarts at 0, so baud_tick follows 16 os_ticks later.
REQ-035 div_int changed 27->40 mid-period -> the current period completes at 27, then periods are 40.
REQ-036 div_int=0 and div_int=1 -> os_tick every 2 clks; enable deasserted mid-period -> no ticks; re-enable -> first os_tick after eff_int clks.
REQ-037 rst asserted mid-bit -> all outputs 0 next cycle; counters restart from 0 after release.
